// File: rtl/dct_pkg.sv
// Shared sizes and types for the EEG DCT front-end controller.
package dct_pkg;
  localparam int SAMPLE_W = 8;
  localparam int COEF_W   = 18;
  localparam int N_PT     = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0]   coef_t;
  typedef sample_t [N_PT-1:0]         frame_t;
  typedef coef_t   [N_PT-1:0]         coefs_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2
  } ctrl_state_t;
endpackage

// File: rtl/dct_ctrl_if.sv
// Sample-in / coefficient-out stream bundle of the DCT controller.
// master = upstream sample source and downstream coefficient sink,
// slave  = the controller itself.
interface dct_ctrl_if;
  import dct_pkg::*;

  logic       in_valid;
  sample_t    in_data;
  logic       in_ready;
  logic       out_valid;
  coef_t      out_data;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/dct_ctrl_obuf.sv
// Coefficient buffer: holds one captured frame of DCT coefficients and
// drains it one coefficient per accepted handshake, index 0 first.
module dct_ctrl_obuf
  import dct_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  coefs_t     i_coefs,
  input  logic       i_ready,
  output logic       o_valid,
  output coef_t      o_data,
  output logic [2:0] o_idx,
  output logic       o_last,
  output logic       o_done
);
  coefs_t     r_coefs;
  logic       r_full;
  logic [2:0] r_idx;
  logic       w_acc;

  assign w_acc   = r_full & i_ready;
  assign o_done  = w_acc & (r_idx == 3'd7);
  assign o_valid = r_full;
  assign o_idx   = r_idx;
  assign o_last  = r_full & (r_idx == 3'd7);
  // Gate data with full so an empty buffer presents zero rather than stale values.
  assign o_data  = r_full ? r_coefs[r_idx] : '0;

  // Coefficient storage: pure data, loaded once per frame at capture.
  always_ff @(posedge clk) begin
    if (i_load) r_coefs <= i_coefs;
  end

  // Full flag and drain index; load only ever happens while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_idx  <= 3'd0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_idx  <= 3'd0;
    end else if (w_acc) begin
      if (r_idx == 3'd7) begin
        r_full <= 1'b0;
        r_idx  <= 3'd0;
      end else begin
        r_idx  <= r_idx + 3'd1;
      end
    end
  end
endmodule

// File: rtl/dct_ctrl.sv
// DCT controller: gathers 8 EEG samples, launches the external DCT core,
// captures its 8 coefficients after DCT_LAT cycles and streams them out.
// Input buffer and coefficient buffer are independent, so the next frame
// fills while the current one computes and drains.
module dct_ctrl
  import dct_pkg::*;
#(
  parameter int DCT_LAT = 3,
  parameter int FCNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  dct_ctrl_if.slave         bus,
  output frame_t            x_o,
  output logic              dct_en,
  output logic              dct_cs,
  output logic              dct_clk8,
  input  coefs_t            z_i,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy
);
  localparam logic [3:0] LAT_INIT = 4'(DCT_LAT - 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next_state;
  logic [3:0]        r_lat;
  logic [3:0]        r_cnt;
  frame_t            r_sbuf;
  frame_t            r_x;
  logic [FCNT_W-1:0] r_frame_cnt;

  logic w_in_ready;
  logic w_in_acc;
  logic w_xfer;
  logic w_capt;
  logic w_obuf_full;
  logic w_frame_done;

  // in_ready is forced low while reset is held.
  assign w_in_ready = reset & (r_cnt < 4'd8);
  assign w_in_acc   = bus.in_valid & w_in_ready;

  assign bus.in_ready = w_in_ready;
  assign dct_clk8     = w_in_acc & (r_cnt == 4'd7);
  assign dct_en       = w_xfer;
  assign dct_cs       = w_xfer | (r_state != IDLE);
  // The core samples x_o together with dct_en, so show the buffer directly
  // in the transfer cycle; r_x keeps it stable for the rest of the compute.
  assign x_o          = w_xfer ? r_sbuf : r_x;
  assign frame_cnt    = r_frame_cnt;
  assign busy         = (r_state != IDLE) | (r_cnt != 4'd0) | w_obuf_full;

  // Sample storage: slot r_cnt takes each accepted sample.
  always_ff @(posedge clk) begin
    if (w_in_acc) r_sbuf[r_cnt[2:0]] <= bus.in_data;
  end

  // Input fill count; a transfer empties it (no accept possible then, count==8).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_cnt <= 4'd0;
    else if (w_xfer)   r_cnt <= 4'd0;
    else if (w_in_acc) r_cnt <= r_cnt + 4'd1;
  end

  // Frame held toward the core for the duration of the compute.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_x <= '0;
    else if (w_xfer) r_x <= r_sbuf;
  end

  // Compute FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Compute FSM next state: launch only into an empty coefficient buffer.
  always_comb begin
    w_next_state = r_state;
    w_xfer       = 1'b0;
    w_capt       = 1'b0;
    case (r_state)
      IDLE: begin
        if ((r_cnt == 4'd8) && !w_obuf_full) begin
          w_xfer       = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (r_lat == 4'd0) w_next_state = CAPT;
      end
      CAPT: begin
        w_capt       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Core latency counter, loaded at launch and counted down while running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_lat <= 4'd0;
    else if (w_xfer)
      r_lat <= LAT_INIT;
    else if ((r_state == RUN) && (r_lat != 4'd0))
      r_lat <= r_lat - 4'd1;
  end

  // Count frames whose last coefficient has been accepted downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_frame_cnt <= '0;
    else if (w_frame_done) r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
  end

  dct_ctrl_obuf u_obuf (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_capt),
    .i_coefs (z_i),
    .i_ready (bus.out_ready),
    .o_valid (w_obuf_full),
    .o_data  (bus.out_data),
    .o_idx   (bus.out_idx),
    .o_last  (bus.out_last),
    .o_done  (w_frame_done)
  );

  assign bus.out_valid = w_obuf_full;
endmodule

// File: tb/tb_dct_ctrl.sv
// Bench for dct_ctrl: directed frames, hand-computed coefficient tables,
// a behavioural DCT core (Z_k = x_k*(k+1)) and a coefficient scoreboard.
// A second instance with a 2-bit frame counter shadows the first.
module tb_dct_ctrl;
  import dct_pkg::*;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  dct_ctrl_if  ifa ();
  dct_ctrl_if  ifb ();
  frame_t      x_a, x_b;
  logic        en_a, cs_a, c8_a, busy_a;
  logic        en_b, cs_b, c8_b, busy_b;
  coefs_t      za, zhold;
  logic [15:0] fc_a;
  logic [1:0]  fc_b;
  logic        dv [LAT];
  coefs_t      dl [LAT];

  int      n_checks = 0;
  int      n_fail   = 0;
  longint  exp_q [$];
  frame_t  frm_q [$];
  int      got [$];
  int      fcb_log [$];
  frame_t  cur;
  int      cur_n = 0;
  int      n_frames = 0;
  int      exp_idx = 0;
  int      en_cnt = 0;
  int      cs_len = 0;
  bit      pend = 0;
  bit      stall_v = 0;
  coef_t   stall_d;
  logic [2:0] stall_i;

  int tbl1 [8] = '{1, 4, 9, 16, 25, 36, 49, 64};
  int tbl2 [8] = '{-128, -256, -384, -512, -640, -768, -896, -1024};
  int tbl3 [5] = '{1, 2, 3, 0, 1};

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_data   = ifa.in_data;
  assign ifb.out_ready = ifa.out_ready;

  dct_ctrl #(.DCT_LAT(LAT), .FCNT_W(16)) dut_a (
    .clk(clk), .reset(rst_n), .bus(ifa), .x_o(x_a), .dct_en(en_a),
    .dct_cs(cs_a), .dct_clk8(c8_a), .z_i(za), .frame_cnt(fc_a), .busy(busy_a)
  );

  dct_ctrl #(.DCT_LAT(LAT), .FCNT_W(2)) dut_b (
    .clk(clk), .reset(rst_n), .bus(ifb), .x_o(x_b), .dct_en(en_b),
    .dct_cs(cs_b), .dct_clk8(c8_b), .z_i(za), .frame_cnt(fc_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic coefs_t core_f(input frame_t x);
    coefs_t  z;
    sample_t s;
    for (int k = 0; k < N_PT; k++) begin
      s    = x[k];
      z[k] = coef_t'(s * (k + 1));
    end
    return z;
  endfunction

  // Behavioural DCT core: result appears LAT cycles after dct_en, then held.
  always @(posedge clk) begin
    dv[0] <= en_a;
    dl[0] <= core_f(x_a);
    for (int i = 1; i < LAT; i++) begin
      dv[i] <= dv[i-1];
      dl[i] <= dl[i-1];
    end
    zhold <= za;
  end
  assign za = dv[LAT-1] ? dl[LAT-1] : zhold;

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic mon_step();
    bit     acc;
    coefs_t zz;
    coef_t  c;
    longint e;
    if (!rst_n) begin
      stall_v = 0;
      return;
    end
    if (pend) begin
      check_val("frame_cnt_a", fc_a, n_frames % 65536);
      check_val("frame_cnt_b", fc_b, n_frames % 4);
      fcb_log.push_back(int'(fc_b));
      pend = 0;
    end
    if (stall_v) begin
      check_val("hold_valid", ifa.out_valid, 1);
      check_val("hold_data", ifa.out_data, stall_d);
      check_val("hold_idx", ifa.out_idx, stall_i);
    end
    stall_v = ifa.out_valid && !ifa.out_ready;
    stall_d = ifa.out_data;
    stall_i = ifa.out_idx;
    acc = ifa.in_valid && ifa.in_ready;
    check_val("dct_clk8", c8_a, (acc && cur_n == 7) ? 1 : 0);
    if (acc) begin
      cur[cur_n] = ifa.in_data;
      cur_n++;
      if (cur_n == 8) begin
        frm_q.push_back(cur);
        zz = core_f(cur);
        for (int k = 0; k < N_PT; k++) begin
          c = zz[k];
          exp_q.push_back(c);
        end
        cur_n = 0;
      end
    end
    if (en_a) begin
      en_cnt++;
      if (frm_q.size() == 0) check_val("dct_en_frame_ready", 0, 1);
      else                   check_val("x_o", x_a, frm_q.pop_front());
    end
    if (cs_a) cs_len++;
    else if (cs_len != 0) begin
      check_val("dct_cs_len", cs_len, LAT + 2);
      cs_len = 0;
    end
    if (ifa.out_valid && ifa.out_ready) begin
      got.push_back(int'(ifa.out_data));
      if (exp_q.size() == 0) check_val("out_expected", 0, 1);
      else begin
        e = exp_q.pop_front();
        check_val("out_data", ifa.out_data, e);
      end
      check_val("out_idx", ifa.out_idx, exp_idx);
      check_val("out_last", ifa.out_last, (exp_idx == 7) ? 1 : 0);
      if (exp_idx == 7) begin
        n_frames++;
        pend = 1;
      end
      exp_idx = (exp_idx + 1) % 8;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_step();
    end
  end

  task automatic check_reset_vals();
    check_val("rst_in_ready", ifa.in_ready, 0);
    check_val("rst_out_valid", ifa.out_valid, 0);
    check_val("rst_out_data", ifa.out_data, 0);
    check_val("rst_out_idx", ifa.out_idx, 0);
    check_val("rst_out_last", ifa.out_last, 0);
    check_val("rst_dct_en", en_a, 0);
    check_val("rst_dct_cs", cs_a, 0);
    check_val("rst_dct_clk8", c8_a, 0);
    check_val("rst_busy", busy_a, 0);
    check_val("rst_x_o", x_a, 0);
    check_val("rst_frame_cnt", fc_a, 0);
    check_val("rst_b_outs", {ifb.in_ready, ifb.out_valid, ifb.out_last, en_b, cs_b, c8_b, busy_b}, 0);
    check_val("rst_b_data", ifb.out_data, 0);
    check_val("rst_b_idx_fc", {ifb.out_idx, fc_b}, 0);
    check_val("rst_b_x_o", x_b, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n   = 1'b0;
    cur_n   = 0;
    exp_q.delete();
    frm_q.delete();
    n_frames = 0;
    exp_idx  = 0;
    cs_len   = 0;
    pend     = 0;
    repeat (cycles) @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("in_ready_after_rst", ifa.in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_sample(input int v, input int bound, output bit ok);
    bit took;
    ok = 0;
    ifa.in_valid = 1'b1;
    ifa.in_data  = sample_t'(v);
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      took = ifa.in_ready;
      @(posedge clk); #1;
      if (took) ok = 1;
    end
    ifa.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    bit done;
    done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (!busy_a && exp_q.size() == 0 && cur_n == 0) done = 1;
    end
    check_val("drain_done", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int n_ok;
    int n_acc;
    int cyc;
    bit took;
    rst_n         = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.in_data   = '0;
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    do_reset(3);

    // Samples 1..8, downstream always ready.
    got.delete();
    en_cnt = 0;
    for (int i = 1; i <= 8; i++) send_sample(i, 20, ok);
    wait_drain(100);
    check_val("t1_count", got.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < got.size()) check_val("t1_coef", got[k], tbl1[k]);
    check_val("t1_dct_en_pulses", en_cnt, 1);
    check_val("t1_frame_cnt", fc_a, 1);

    // Full-scale negative samples.
    got.delete();
    for (int i = 0; i < 8; i++) send_sample(-128, 20, ok);
    wait_drain(100);
    check_val("t2_count", got.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < got.size()) check_val("t2_coef", got[k], tbl2[k]);
    check_val("t2_frame_cnt", fc_a, 2);

    // Downstream blocked: only two frames fit (one computed, one buffered).
    got.delete();
    ifa.out_ready = 1'b0;
    n_ok = 0;
    for (int i = 0; i < 24; i++) begin
      send_sample(i * 5 - 40, 20, ok);
      if (ok) n_ok++;
    end
    @(negedge clk);
    check_val("t4_accepted", n_ok, 16);
    check_val("t4_in_ready_low", ifa.in_ready, 0);
    check_val("t4_out_valid_stalled", ifa.out_valid, 1);
    @(posedge clk); #1;
    ifa.out_ready = 1'b1;
    wait_drain(200);
    check_val("t4_coefs_out", got.size(), 16);
    check_val("t4_frame_cnt", fc_a, 4);

    // Reset in the middle of a frame discards it.
    for (int i = 0; i < 5; i++) send_sample(100 + i, 20, ok);
    do_reset(2);
    got.delete();
    en_cnt = 0;
    for (int i = 0; i < 8; i++) send_sample(7 - i * 9, 20, ok);
    wait_drain(100);
    check_val("t5_coefs_out", got.size(), 8);
    check_val("t5_dct_en_pulses", en_cnt, 1);
    check_val("t5_frame_cnt", fc_a, 1);

    // 100 back-to-back frames with random downstream stalls.
    do_reset(2);
    got.delete();
    fcb_log.delete();
    n_acc = 0;
    cyc   = 0;
    ifa.in_valid = 1'b1;
    ifa.in_data  = sample_t'($urandom_range(0, 255));
    while (n_acc < 800 && cyc < 20000) begin
      @(negedge clk);
      took = ifa.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        n_acc++;
        ifa.in_data = sample_t'($urandom_range(0, 255));
      end
      ifa.out_ready = ($urandom_range(0, 3) != 0);
    end
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    check_val("t6_accepted", n_acc, 800);
    wait_drain(4000);
    check_val("t6_coefs_out", got.size(), 800);
    check_val("t6_frame_cnt", fc_a, 100);
    check_val("t6_frame_cnt_b", fc_b, 0);
    check_val("t6_fcb_logged", (fcb_log.size() >= 5) ? 1 : 0, 1);
    for (int k = 0; k < 5; k++)
      if (k < fcb_log.size()) check_val("t6_fcb_seq", fcb_log[k], tbl3[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dct_ctrl.md
DCT_CTRL -- requirements
Module: dct_ctrl

Interface
REQ-001 Parameter DCT_LAT, default 3, cycles from dct_en pulse to valid coefficients on z_i; legal 1..15.
REQ-002 Parameter FCNT_W, default 16, width of frame counter.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  sample valid.
REQ-006 in_data  in  8  signed EEG sample.
REQ-007 in_ready  out  1  sample accepted when in_valid&in_ready.
REQ-008 x_o  out  8x8  frame to DCT core, element k = sample k of frame; held stable during compute.
REQ-009 dct_en  out  1  one-cycle start pulse to DCT core.
REQ-010 dct_cs  out  1  core select, high from dct_en cycle through capture cycle.
REQ-011 dct_clk8  out  1  one-cycle frame strobe, high on the cycle the 8th sample is accepted.
REQ-012 z_i  in  8x18  signed coefficients Z0..Z7 from DCT core.
REQ-013 out_valid  out  1  coefficient valid.
REQ-014 out_data  out  18  signed coefficient.
REQ-015 out_idx  out  3  coefficient index 0..7.
REQ-016 out_last  out  1  high with out_idx==7.
REQ-017 out_ready  in  1  downstream (RLE) accept.
REQ-018 frame_cnt  out  FCNT_W  frames fully drained, wraps modulo 2^FCNT_W.
REQ-019 busy  out  1  high when any state is not IDLE or any buffer is non-empty.

Function
REQ-020 Input side: 8-entry sample buffer plus 4-bit fill count; in_ready = (count<8).
REQ-021 Accepted sample writes slot count; count increments; 8th accept sets dct_clk8 for that cycle.
REQ-022 Compute FSM states: IDLE, RUN, CAPT.
REQ-023 IDLE->RUN when count==8 and coefficient buffer empty: copy samples to x_o, count->0, dct_en=1, dct_cs=1 that cycle.
REQ-024 RUN: latency counter loads DCT_LAT-1 and decrements; at 0 -> CAPT.
REQ-025 CAPT: latch all 8 z_i into coefficient buffer, mark buffer full, drop dct_cs next cycle, -> IDLE.
REQ-026 In_ready reasserts the cycle after transfer; next frame fills during RUN/CAPT/drain (double buffering).
REQ-027 Drain: while coefficient buffer full, out_valid=1, out_data=Z[idx], out_idx=idx; idx advances on out_valid&out_ready.
REQ-028 out_data/out_idx stable while out_valid&!out_ready.
REQ-029 Accept of idx 7: buffer empty, idx->0, frame_cnt+1 (wraps 2^FCNT_W-1 -> 0).
REQ-030 Next IDLE->RUN transfer permitted the cycle after last accept, never same cycle.
REQ-031 Full input buffer with compute/drain pending: in_ready=0, samples held upstream, none lost.
REQ-032 Simultaneous final in-accept and final out-accept: both take effect; transfer occurs next cycle.
REQ-033 Back-to-back frames with out_ready=1 and in_valid=1 continuously: no sample or coefficient dropped or duplicated.

Reset
REQ-034 reset low: FSM IDLE, count=0, idx=0, buffers empty, x_o=0, frame_cnt=0, in_ready=0 while asserted then 1, dct_en=dct_cs=dct_clk8=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
REQ-035 Reset mid-frame or mid-drain discards partial frame and pending coefficients; no output after release until a new full frame.

Structure
REQ-036 Shared package dct_pkg holds SAMPLE_W=8, COEF_W=18, N_PT=8, sample_t, coef_t, frame_t (8 x sample_t), coefs_t (8 x coef_t), ctrl_state_t enum.
REQ-037 One sub-module dct_ctrl_obuf (coefficient buffer + drain counter); remainder flat in dct_ctrl.

Verification (DCT core replaced by model: Z_k = x_k*(k+1), latency DCT_LAT)
REQ-038 Samples 1..8, out_ready=1 -> dct_en one pulse exactly DCT_LAT cycles before capture; outputs 1,4,9,16,25,36,49,64, idx 0..7, out_last on 64, frame_cnt=1.
REQ-039 Samples -128 x8 -> outputs -128,-256,...,-1024 sign-correct in 18 bits.
REQ-040 out_ready=0 with 24 samples offered -> exactly 16 accepted then in_ready=0; release -> 16 coefficients in order, no loss.
REQ-041 Reset asserted after 5 samples accepted -> after release, 8 new samples yield exactly one frame, frame_cnt=1.
REQ-042 Continuous 100 frames, random out_ready stalls -> scoreboard exact match, frame_cnt=100.
REQ-043 FCNT_W=2, 5 frames -> frame_cnt sequence 1,2,3,0,1.
